lc3_mem_ctrl: RTL and testbench

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

---
 rtl/lc3_mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: a RAM plus the display device registers DSR and DDR,
// behind a req/ready handshake with a configurable number of wait states.
//
// Parameters:
//   WAIT_STATES  idle cycles between acceptance and completion (0..15)
//   DEPTH_LOG2   RAM holds 2**DEPTH_LOG2 16-bit words
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   req         access request, sampled only in IDLE
//   we          1 = write, 0 = read, sampled with req
//   addr        word address (MAR), sampled with req
//   wdata       write data (MDR), sampled with req
//   rdata       read data, valid with ready, held until the next read completion
//   ready       one-cycle completion pulse
//   busy        high from the cycle after acceptance through the ready cycle
//   disp_data   display character register (DDR[7:0])
//   disp_valid  display character pending
//   disp_ack    display consumed the character
module lc3_mem_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] IO_BASE  = 16'hFE00;
    localparam logic [15:0] DSR_ADDR = 16'hFE04;
    localparam logic [15:0] DDR_ADDR = 16'hFE06;

    // Counter value seen in the last WAIT cycle; the access completes at that edge.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;

    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;

    logic        accept;
    logic        commit;
    logic        acc_we;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        ram_sel;
    logic        dsr_sel;
    logic        ddr_sel;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [15:0] read_value;

    logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

    assign accept = (state == IDLE) && req;

    // Next-state logic. commit marks the edge that enters DONE, where the
    // access takes effect; reset suppresses it so an aborted access leaves
    // the (unreset) RAM untouched.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign commit = (state_next == DONE) && !rst;

    // With zero wait states the access commits at the acceptance edge itself,
    // before the latches hold it, so the live inputs are used while in IDLE.
    assign acc_we    = (state == IDLE) ? we    : lat_we;
    assign acc_addr  = (state == IDLE) ? addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? wdata : lat_wdata;

    assign ram_sel = (acc_addr < IO_BASE);
    assign dsr_sel = (acc_addr == DSR_ADDR);
    assign ddr_sel = (acc_addr == DDR_ADDR);
    assign ram_idx = acc_addr[DEPTH_LOG2-1:0];

    always_comb begin
        read_value = 16'h0000;
        if (ram_sel) begin
            read_value = mem[ram_idx];
        end else if (dsr_sel) begin
            read_value = {~disp_valid, 15'b0};
        end else if (ddr_sel) begin
            read_value = {8'h00, disp_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                wait_cnt <= 4'd0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
        end else if (accept) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && acc_we && ram_sel) begin
            mem[ram_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 16'h0000;
        end else if (commit && !acc_we) begin
            rdata <= read_value;
        end
    end

    // A DDR write at the same edge as disp_ack wins: the new character is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data  <= 8'h00;
            disp_valid <= 1'b0;
        end else if (commit && acc_we && ddr_sel) begin
            disp_data  <= acc_wdata[7:0];
            disp_valid <= 1'b1;
        end else if (disp_ack) begin
            disp_valid <= 1'b0;
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed scenarios plus randomized
// accesses checked against a transaction-level model of RAM and display.
module tb_lc3_mem_ctrl;

    localparam int WS = 2;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ack;

    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [15:0] wdata0;
    logic [15:0] rdata0;
    logic        ready0;
    logic        busy0;
    logic [7:0]  disp_data0;
    logic        disp_valid0;
    logic        disp_ack0;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] m_mem [256];
    logic [7:0]  m_ddata;
    logic        m_dvalid;
    logic [15:0] m_rdata;

    lc3_mem_ctrl #(.WAIT_STATES(WS), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy),
        .disp_data(disp_data), .disp_valid(disp_valid), .disp_ack(disp_ack)
    );

    lc3_mem_ctrl #(.WAIT_STATES(0), .DEPTH_LOG2(8)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .busy(busy0),
        .disp_data(disp_data0), .disp_valid(disp_valid0), .disp_ack(disp_ack0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'hFE00) return m_mem[a[7:0]];
        if (a == 16'hFE04) return m_dvalid ? 16'h0000 : 16'h8000;
        if (a == 16'hFE06) return {8'h00, m_ddata};
        return 16'h0000;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
        if (a < 16'hFE00) begin
            m_mem[a[7:0]] = d;
        end else if (a == 16'hFE06) begin
            m_ddata  = d[7:0];
            m_dvalid = 1'b1;
        end
    endfunction

    // One access on the WS=2 instance, started and ended at a falling edge
    // with the controller idle. ack_k > 0 pulses disp_ack during the k-th
    // cycle after acceptance (k == WS is the cycle ending at the commit edge).
    task automatic apply_stimulus(input logic w, input logic [15:0] a, input logic [15:0] d,
                                  input int ack_k, input string tag);
        int k;
        bit done;
        bit ddr_write;
        ddr_write = w && (a == 16'hFE06);
        if (ack_k > 0 && ack_k < WS) m_dvalid = 1'b0;
        if (w) model_write(a, d);
        else   m_rdata = model_read(a);
        if (ack_k == WS && !ddr_write) m_dvalid = 1'b0;
        if (ack_k > WS) m_dvalid = 1'b0;

        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        k = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            if (disp_ack) disp_ack = 1'b0;
            if (k == ack_k) disp_ack = 1'b1;
            check_output({tag, "_busy"}, 16'(busy), 16'h0001);
            if (ready) done = 1'b1;
        end
        check_output({tag, "_latency"}, 16'(k), 16'(WS + 1));
        check_output({tag, "_rdata"}, rdata, m_rdata);
        @(negedge clk);
        if (disp_ack) disp_ack = 1'b0;
        check_output({tag, "_ready_low"}, 16'(ready), 16'h0000);
        check_output({tag, "_busy_low"}, 16'(busy), 16'h0000);
        check_output({tag, "_dvalid"}, 16'(disp_valid), 16'(m_dvalid));
        check_output({tag, "_ddata"}, 16'(disp_data), 16'(m_ddata));
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        int r;
        int ak;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000; disp_ack = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000; wdata0 = 16'h0000; disp_ack0 = 1'b0;
        m_ddata = 8'h00; m_dvalid = 1'b0; m_rdata = 16'h0000;
        repeat (3) @(negedge clk);
        check_output("rst_ready", 16'(ready), 16'h0000);
        check_output("rst_busy", 16'(busy), 16'h0000);
        check_output("rst_rdata", rdata, 16'h0000);
        check_output("rst_ddata", 16'(disp_data), 16'h0000);
        check_output("rst_dvalid", 16'(disp_valid), 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // RAM is not reset, so give every word a known value (through random aliases).
        for (int i = 0; i < 256; i++) begin
            a = 16'(i + 256 * $urandom_range(0, 16'hFD));
            apply_stimulus(1'b1, a, 16'($urandom), 0, "init");
        end

        apply_stimulus(1'b1, 16'h0010, 16'h1234, 0, "wr0010");
        apply_stimulus(1'b0, 16'h0010, 16'h0000, 0, "rd0010");
        check_output("rd0010_val", rdata, 16'h1234);

        apply_stimulus(1'b1, 16'h0105, 16'hBEEF, 0, "wr0105");
        apply_stimulus(1'b0, 16'h0005, 16'h0000, 0, "rd0005");
        check_output("alias_val", rdata, 16'hBEEF);

        apply_stimulus(1'b1, 16'hFE06, 16'h0041, 0, "wr_ddr41");
        check_output("ddr41_data", 16'(disp_data), 16'h0041);
        check_output("ddr41_valid", 16'(disp_valid), 16'h0001);
        apply_stimulus(1'b0, 16'hFE04, 16'h0000, 0, "rd_dsr_busy");
        check_output("dsr_pending", rdata, 16'h0000);
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
        m_dvalid = 1'b0;
        check_output("ack_clears", 16'(disp_valid), 16'h0000);
        apply_stimulus(1'b0, 16'hFE04, 16'h0000, 0, "rd_dsr_ready");
        check_output("dsr_ready", rdata, 16'h8000);

        apply_stimulus(1'b1, 16'hFE06, 16'h0041, 0, "wr_ddr41b");
        apply_stimulus(1'b1, 16'hFE06, 16'h0042, WS, "ddr42_ack");
        check_output("ddr42_valid", 16'(disp_valid), 16'h0001);
        check_output("ddr42_data", 16'(disp_data), 16'h0042);
        apply_stimulus(1'b1, 16'hFE06, 16'h0043, 0, "ddr43_over");
        check_output("ddr43_data", 16'(disp_data), 16'h0043);
        apply_stimulus(1'b0, 16'hFE06, 16'h0000, 0, "rd_ddr");
        check_output("rd_ddr_val", rdata, 16'h0043);
        apply_stimulus(1'b0, 16'hFE10, 16'h0000, 0, "rd_unmapped");
        check_output("unmapped_val", rdata, 16'h0000);

        // Reset in the middle of a write: access is abandoned.
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'hAAAA;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_rdata = 16'h0000; m_ddata = 8'h00; m_dvalid = 1'b0;
        check_output("abort_busy", 16'(busy), 16'h0000);
        check_output("abort_ready", 16'(ready), 16'h0000);
        check_output("abort_rdata", rdata, 16'h0000);
        check_output("abort_dvalid", 16'(disp_valid), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("abort_no_ready", 16'(ready), 16'h0000);
        end
        apply_stimulus(1'b0, 16'h0020, 16'h0000, 0, "rd0020_after_abort");

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       a = 16'($urandom_range(0, 16'hFDFF));
            else if (r == 6) a = 16'hFE04;
            else if (r == 7) a = 16'hFE06;
            else             a = 16'(16'hFE00 + $urandom_range(0, 511));
            d = 16'($urandom);
            ak = ($urandom_range(0, 1) == 1) ? $urandom_range(1, WS + 1) : 0;
            apply_stimulus(1'($urandom_range(0, 1)), a, d, ak, "rand");
        end

        // Zero-wait-state instance.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0003; wdata0 = 16'h5A5A;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        check_output("ws0_wr_ready", 16'(ready0), 16'h0001);
        check_output("ws0_wr_busy", 16'(busy0), 16'h0001);
        @(negedge clk);
        check_output("ws0_wr_idle", 16'(ready0), 16'h0000);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0003;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        check_output("ws0_rd_ready", 16'(ready0), 16'h0001);
        check_output("ws0_rd_val", rdata0, 16'h5A5A);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'hFE10;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_output("ws0_held_ready", 16'(ready0), 16'(i % 2));
            if (i % 2 == 1) check_output("ws0_unmapped", rdata0, 16'h0000);
        end
        req0 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
